// File: rtl/riscv_pkg.sv
// Shared definitions for the execute-stage units: operand width, M-extension
// divide op encodings and the divider state type.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ITER = XLEN;

  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/adder32.sv
// Plain 32-bit ripple adder with carry in/out; the divider uses it as a
// subtractor by feeding the inverted subtrahend and carryin=1.
module adder32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        carryin,
  output logic [31:0] sum,
  output logic        carryout
);

  assign {carryout, sum} = {1'b0, x} + {1'b0, y} + {32'b0, carryin};

endmodule

// File: rtl/div32_seq.sv
// Restoring one-bit-per-cycle divider for RV32M DIV/DIVU/REM/REMU. Signed
// ops divide magnitudes and fix the signs in a single FIX cycle at the end.
module div32_seq
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_t state, state_next;

  logic            sel_rem;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] divisor_abs;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] result_q;
  logic [4:0]      count;

  logic            signed_op;
  logic [XLEN-1:0] dividend_abs;
  logic [XLEN-1:0] divisor_in_abs;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] rem_shift;
  logic [XLEN-1:0] trial_diff;
  logic            trial_carry;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign signed_op      = ~op[0];
  assign dividend_abs   = (signed_op && dividend[XLEN-1]) ? (~dividend + 32'd1) : dividend;
  assign divisor_in_abs = (signed_op && divisor[XLEN-1])  ? (~divisor + 32'd1)  : divisor;
  assign div_zero       = (divisor == 32'd0);
  assign overflow       = signed_op && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

  // The dividend magnitude lives in quo and shifts into rem one bit per cycle.
  assign rem_shift = {rem[XLEN-2:0], quo[XLEN-1]};

  adder32 u_trial_sub (
    .x        (rem_shift),
    .y        (~divisor_abs),
    .carryin  (1'b1),
    .sum      (trial_diff),
    .carryout (trial_carry)
  );

  assign quo_fix = neg_q ? (~quo + 32'd1) : quo;
  assign rem_fix = neg_r ? (~rem + 32'd1) : rem;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (div_zero || overflow) ? DONE : CALC;
      CALC: if (count == 5'd0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Special cases load result directly on the accepting edge and skip CALC.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_rem     <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      divisor_abs <= '0;
      rem         <= '0;
      quo         <= '0;
      count       <= '0;
      result_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel_rem     <= op[1];
            neg_q       <= signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r       <= signed_op && dividend[XLEN-1];
            divisor_abs <= divisor_in_abs;
            rem         <= '0;
            quo         <= dividend_abs;
            count       <= 5'(ITER - 1);
            if (div_zero)
              result_q <= op[1] ? dividend : 32'hFFFF_FFFF;
            else if (overflow)
              result_q <= op[1] ? 32'd0 : 32'h8000_0000;
          end
        end
        CALC: begin
          if (trial_carry) begin
            rem <= trial_diff;
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= rem_shift;
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          count <= count - 5'd1;
        end
        FIX: result_q <= sel_rem ? rem_fix : quo_fix;
        default: ;
      endcase
    end
  end

  assign busy   = (state == CALC) || (state == FIX);
  assign done   = (state == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div32_seq.sv
// Directed-vector bench for div32_seq: results, latency, busy/done timing,
// ignored starts and reset abort, with hand-computed expectations.
module tb_div32_seq;
  import riscv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  div32_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issues one operation and follows it to done. A nonzero intr_cycle drives
  // a second start with different operands on that edge count.
  task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_result,
                               input int exp_edges, input int intr_cycle);
    int edges;
    int busy_cycles;
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    busy_cycles = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cycles++;
      if (edges == intr_cycle) begin
        start = 1'b1; op = DIVU_OP; dividend = 32'd50; divisor = 32'd5;
      end else begin
        start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'd1;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_edges"}, edges, exp_edges);
    checkOutput({tag, "_result"}, result, exp_result);
    checkOutput({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_busy_cycles"}, busy_cycles, (exp_edges > 1) ? exp_edges - 1 : 0);
    @(posedge clk); #1;
    checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_result_held"}, result, exp_result);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; start = 1'b0; op = DIVU_OP; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("divu_100_7", DIVU_OP, 32'd100, 32'd7, 32'd14, 34, 0);
    applyStimulus("remu_100_7", REMU_OP, 32'd100, 32'd7, 32'd2, 34, 0);
    applyStimulus("div_m7_2", DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    applyStimulus("rem_m7_2", REM_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    applyStimulus("rem_7_m2", REM_OP, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0);
    applyStimulus("div_m7_m2", DIV_OP, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 34, 0);
    applyStimulus("divu_5_0", DIVU_OP, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    applyStimulus("remu_5_0", REMU_OP, 32'd5, 32'd0, 32'd5, 1, 0);
    applyStimulus("div_m7_0", DIV_OP, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, 0);
    applyStimulus("rem_m7_0", REM_OP, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 0);
    applyStimulus("div_ovf", DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    applyStimulus("rem_ovf", REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    applyStimulus("divu_big", DIVU_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 0);
    applyStimulus("remu_big", REMU_OP, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    applyStimulus("divu_ignored_start", DIVU_OP, 32'd1000, 32'd3, 32'd333, 34, 5);

    // Abort a division with reset mid-flight; no done may follow.
    @(negedge clk);
    start = 1'b1; op = DIVU_OP; dividend = 32'd1000; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_result", result, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);

    applyStimulus("divu_9_3", DIVU_OP, 32'd9, 32'd3, 32'd3, 34, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
- Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Uses a restoring, one-bit-per-cycle algorithm with subtraction performed by the existing adder32 (X + ~Y + 1).
- Sits beside the ALU in execute. The core stalls on busy and captures result on done.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, number of quotient bits produced (fixed equal to XLEN).

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  32  rs1 value, captured on the accepted start
- divisor  in  32  rs2 value, captured on the accepted start
- busy  out  1  high from the edge after an accepted start until done
- done  out  1  one-cycle pulse when result is valid
- result  out  32  quotient or remainder; held until the next accepted start

Behaviour:
- Reset, synchronous, active-high, dominant over everything:
  - state=IDLE; busy=0, done=0, result=0.
  - Asserting reset mid-operation aborts the division with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 captures op and operands.
  - Signed ops (DIV/REM) take absolute values and record neg_q = sign(a) XOR sign(b) and neg_r = sign(a).
  - Next state: DONE on divisor==0 or signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF); CALC otherwise.
- CALC, 32 cycles, counter 31 down to 0:
  - rem_shift = {rem[30:0], quo[31]}; quo <<= 1.
  - Trial value = rem_shift - |divisor| through adder32, carryin=1.
  - carryout=1 (no borrow): rem = difference, quo[0] = 1.
  - Otherwise: rem = rem_shift, quo[0] = 0.
  - Leaves for FIX after the iteration with counter 0.
- FIX:
  - Negate quo if neg_q; negate rem if neg_r (signed ops only).
  - Select quotient for DIV/DIVU, remainder for REM/REMU; register into result.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. result persists.
- Special cases (result loaded on entry to DONE):
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend (unsigned and signed).
  - Signed overflow: quotient = 0x80000000, remainder = 0.
- Latency:
  - Normal: done visible after the 34th rising edge following the edge that accepted start (1 entry + 32 CALC + 1 FIX; done in cycle 35).
  - Special cases: done visible after the 1st edge following the accepted start.
- start while not in IDLE is ignored; operand changes while busy are ignored.
- start in the same cycle done is high is ignored, because state is DONE, not IDLE.
- busy = (state == CALC || state == FIX).
- All arithmetic is modulo 2^32. Negation is ~x + 1. |0x80000000| is handled unsigned as 0x80000000.

Decomposition:
- Shared package riscv_pkg:
  - op encodings DIV_OP=2'b00, DIVU_OP=2'b01, REM_OP=2'b10, REMU_OP=2'b11.
  - div_state_t enum {IDLE, CALC, FIX, DONE}.
  - XLEN constant.
- One sub-module: adder32, instantiated once as the trial subtractor (X=rem_shift, Y=~divisor_abs, carryin=1).
- Operand negations are inline expressions.

Test Plan:
- DIVU 100/7, then REMU 100/7 -> result 14 and 2. done pulses exactly one cycle, 34 edges after start; busy high for those 33 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). REM 7/0xFFFFFFFE -> 1.
- DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0xFFFFFFF9/0 -> 0xFFFFFFFF. Each has done one edge after start.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. Both take the fast path. DIVU 0x80000000/0xFFFFFFFF -> 0 via normal path.
- Start DIVU 1000/3. Pulse start with new operands at cycle 5 -> ignored; result 333.
- Start DIVU 1000/3 and assert reset at cycle 10 -> busy=0, result=0, no done pulse. A following DIVU 9/3 -> 3.
